data_mem_responder: RTL and testbench

//  Memory-side responder for the pipeline's load/store interface (mem_read/mem_write/addr/write_data).

---
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 tb/tb_data_mem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Slow word-addressed data RAM responder with WAIT_CYCLES wait states and a one-cycle response.
// Define DMEM_PARITY_EN to store an even-parity bit per word and flag mismatches on loads.
module data_mem_responder #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              pc_reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  output logic              mem_busy,
  output logic              addr_err,
  output logic              parity_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              parity_err_q, parity_err_d;
  logic              busy;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] ram_out;
  logic              in_range, access, we, par_bad;

  assign in_range = (32'(addr_q) < DEPTH);
  assign idx      = addr_q[AW-1:0];
  assign ram_out  = mem_q[idx];
  assign access   = (state_q == StWait) && (cnt_q == 4'd0);
  // A dual-op request is rejected outright, so it never writes.
  assign we       = access & wr_q & ~rd_q & in_range;

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata_q;
  end

`ifdef DMEM_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) par_q[idx] <= ^wdata_q;
  end

  assign par_bad = (^ram_out) != par_q[idx];
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    rdata_d      = rdata_q;
    rd_valid_d   = 1'b0;
    addr_err_d   = 1'b0;
    parity_err_d = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = mem_read | mem_write;
        if (mem_read | mem_write) begin
          addr_d  = addr;
          wdata_d = write_data;
          rd_d    = mem_read;
          wr_d    = mem_write;
          cnt_d   = 4'(WAIT_CYCLES - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        busy = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          if (rd_q && wr_q) begin
            addr_err_d = 1'b1;
          end else if (rd_q) begin
            rd_valid_d = 1'b1;
            if (in_range) begin
              rdata_d      = ram_out;
              parity_err_d = par_bad;
            end else begin
              rdata_d    = '0;
              addr_err_d = 1'b1;
            end
          end else if (!in_range) begin
            addr_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      addr_q       <= 16'd0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      rdata_q      <= '0;
      rd_valid_q   <= 1'b0;
      addr_err_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      rdata_q      <= rdata_d;
      rd_valid_q   <= rd_valid_d;
      addr_err_q   <= addr_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign read_data  = rdata_q;
  assign rd_valid   = rd_valid_q;
  assign addr_err   = addr_err_q;
  assign parity_err = parity_err_q;
  assign mem_busy   = busy & pc_reset_n;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a per-cycle expectation model checked on every negedge,
// plus literal checks on captured response values.
module tb_data_mem_responder;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned WC    = 2;

  logic          clk = 1'b0;
  logic          pc_reset_n = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [15:0]   addr = 16'd0;
  logic [DW-1:0] write_data = '0;
  logic [DW-1:0] read_data;
  logic          rd_valid, mem_busy, addr_err, parity_err;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DATA_W(DW),
    .DEPTH(DEPTH),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk),
    .pc_reset_n(pc_reset_n),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .addr(addr),
    .write_data(write_data),
    .read_data(read_data),
    .rd_valid(rd_valid),
    .mem_busy(mem_busy),
    .addr_err(addr_err),
    .parity_err(parity_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic          chk = 1'b0;
  logic          exp_busy = 1'b0, exp_rv = 1'b0, exp_aerr = 1'b0, exp_perr = 1'b0;
  logic [DW-1:0] exp_rdata = '0;
  logic [DW-1:0] model_mem [DEPTH];

  int            nbusy;
  logic [DW-1:0] cap_rdata, resp_rdata;
  logic          cap_rv, cap_aerr, cap_perr, resp_rv, resp_aerr, resp_perr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("mem_busy",   32'(mem_busy),   32'(exp_busy));
      check("rd_valid",   32'(rd_valid),   32'(exp_rv));
      check("addr_err",   32'(addr_err),   32'(exp_aerr));
      check("parity_err", 32'(parity_err), 32'(exp_perr));
      check("read_data",  32'(read_data),  32'(exp_rdata));
    end
  end

  task automatic cycle(input logic r, input logic w, input logic [15:0] a, input logic [DW-1:0] d,
                       input logic busy, input logic rv, input logic aerr, input logic perr);
    @(posedge clk);
    #1;
    mem_read   = r;
    mem_write  = w;
    addr       = a;
    write_data = d;
    exp_busy   = busy;
    exp_rv     = rv;
    exp_aerr   = aerr;
    exp_perr   = perr;
    @(negedge clk);
    #1;
    if (mem_busy) nbusy++;
    cap_rdata = read_data;
    cap_rv    = rd_valid;
    cap_aerr  = addr_err;
    cap_perr  = parity_err;
  endtask

  // Request held through RESP (must not be re-sampled), junk addr/data during WAIT (ignored).
  task automatic access(input logic r, input logic w, input logic [15:0] a,
                        input logic [DW-1:0] d, input logic perr);
    logic in_r, rv, aerr;
    in_r = (32'(a) < DEPTH);
    rv   = 1'b0;
    aerr = 1'b0;
    nbusy = 0;
    cycle(r, w, a, d, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(WC); i++)
      cycle(r, w, a ^ 16'h5A5A, ~d, 1'b1, 1'b0, 1'b0, 1'b0);
    if (r && w) begin
      aerr = 1'b1;
    end else if (r) begin
      rv = 1'b1;
      if (in_r) begin
        exp_rdata = model_mem[a[7:0]];
      end else begin
        exp_rdata = '0;
        aerr      = 1'b1;
      end
    end else begin
      if (in_r) model_mem[a[7:0]] = d;
      else aerr = 1'b1;
    end
    cycle(r, w, a, d, 1'b0, rv, aerr, perr & r & ~w & in_r);
    resp_rdata = cap_rdata;
    resp_rv    = cap_rv;
    resp_aerr  = cap_aerr;
    resp_perr  = cap_perr;
    cycle(1'b0, 1'b0, 16'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;

    // Reset held low
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  32'(mem_busy),   32'h0);
    check("rst_rv",    32'(rd_valid),   32'h0);
    check("rst_aerr",  32'(addr_err),   32'h0);
    check("rst_perr",  32'(parity_err), 32'h0);
    check("rst_rdata", 32'(read_data),  32'h0);
    pc_reset_n = 1'b1;
    chk = 1'b1;
    @(posedge clk);

    // Write then read back
    access(1'b0, 1'b1, 16'd5, 16'hBEEF, 1'b0);
    check("wr5_busy_cycles", 32'(nbusy), 32'd3);
    check("wr5_no_rv", 32'(resp_rv), 32'h0);
    access(1'b1, 1'b0, 16'd5, 16'h0000, 1'b0);
    check("rd5_busy_cycles", 32'(nbusy), 32'd3);
    check("rd5_data", 32'(resp_rdata), 32'hBEEF);
    check("rd5_rv", 32'(resp_rv), 32'h1);

    // Out-of-range read does not alias onto addr 44
    access(1'b0, 1'b1, 16'd44, 16'h4444, 1'b0);
    access(1'b1, 1'b0, 16'd300, 16'h0000, 1'b0);
    check("rd300_aerr", 32'(resp_aerr), 32'h1);
    check("rd300_rv", 32'(resp_rv), 32'h1);
    check("rd300_data", 32'(resp_rdata), 32'h0);
    access(1'b1, 1'b0, 16'd44, 16'h0000, 1'b0);
    check("rd44_data", 32'(resp_rdata), 32'h4444);

    // Dual-op rejected, RAM[7] untouched
    access(1'b0, 1'b1, 16'd7, 16'h0707, 1'b0);
    access(1'b1, 1'b1, 16'd7, 16'hDEAD, 1'b0);
    check("dual_aerr", 32'(resp_aerr), 32'h1);
    check("dual_rv", 32'(resp_rv), 32'h0);
    access(1'b1, 1'b0, 16'd7, 16'h0000, 1'b0);
    check("rd7_data", 32'(resp_rdata), 32'h0707);

    // Address boundaries
    access(1'b0, 1'b1, 16'd255, 16'hA5A5, 1'b0);
    access(1'b0, 1'b1, 16'd256, 16'h1111, 1'b0);
    check("wr256_aerr", 32'(resp_aerr), 32'h1);
    access(1'b1, 1'b0, 16'd255, 16'h0000, 1'b0);
    check("rd255_data", 32'(resp_rdata), 32'hA5A5);
    access(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
    check("rdffff_aerr", 32'(resp_aerr), 32'h1);

    // Reset in the middle of WAIT aborts the write
    access(1'b0, 1'b1, 16'd9, 16'h0909, 1'b0);
    nbusy = 0;
    cycle(1'b0, 1'b1, 16'd9, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 16'd9, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    pc_reset_n = 1'b0;
    mem_write  = 1'b0;
    exp_busy   = 1'b0;
    exp_rdata  = '0;
    #1;
    check("midrst_busy",  32'(mem_busy),  32'h0);
    check("midrst_rv",    32'(rd_valid),  32'h0);
    check("midrst_aerr",  32'(addr_err),  32'h0);
    check("midrst_rdata", 32'(read_data), 32'h0);
    @(posedge clk);
    #1;
    pc_reset_n = 1'b1;
    access(1'b1, 1'b0, 16'd9, 16'h0000, 1'b0);
    check("rd9_old", 32'(resp_rdata), 32'h0909);

`ifdef DMEM_PARITY_EN
    access(1'b0, 1'b1, 16'd3, 16'h00F0, 1'b0);
    @(negedge clk);
    dut.mem_q[3] = 16'h00F1;
    model_mem[3] = 16'h00F1;
    access(1'b1, 1'b0, 16'd3, 16'h0000, 1'b1);
    check("rd3_perr", 32'(resp_perr), 32'h1);
    check("rd3_data", 32'(resp_rdata), 32'h00F1);
`else
    access(1'b0, 1'b1, 16'd3, 16'h00F0, 1'b0);
    access(1'b1, 1'b0, 16'd3, 16'h0000, 1'b0);
    check("rd3_noperr", 32'(resp_perr), 32'h0);
    check("rd3_data", 32'(resp_rdata), 32'h00F0);
`endif

    chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
